pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Resolves load-use hazards, taken-branch redirects, instruction-fetch wait and data-memory wait.
- Times out a stuck data-memory access.
- Sits beside the datapath in the top-level CPU; purely a control block, no datapath state.

Parameters:
MEM_TIMEOUT, 16, max consecutive data-memory wait cycles before abort (≥2)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
rs1_ID  in  5  ID-stage source register 1
rs2_ID  in  5  ID-stage source register 2
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_EX  in  5  EX-stage destination register
MemRead_EX  in  1  EX instruction is a load
branch_taken_EX  in  1  EX resolved taken branch/jump (PC loads target)
imem_ready  in  1  instruction fetch data valid this cycle
dmem_req_MEM  in  1  MEM stage issues load/store
dmem_ready  in  1  data memory completes access this cycle
PC_EN  out  1  PC write enable
IF_ID_EN  out  1  IF_ID enable
IF_ID_flush  out  1  IF_ID loads bubble (nop, PC 0)
ID_EX_EN  out  1  ID_EX enable
ID_EX_flush  out  1  ID_EX loads bubble
EX_MEM_EN  out  1  EX_MEM enable
MEM_WB_EN  out  1  MEM_WB enable
mem_timeout  out  1  one-cycle pulse: data access aborted
state_o  out  1  0=RUN, 1=MEM_WAIT

Behaviour:
- Control outputs are combinational from state and inputs, same cycle. mem_timeout, state and counters are registered.
- While rst=1: all *_EN=1, IF_ID_flush=ID_EX_flush=1, mem_timeout=0, state=RUN, wait counter=0. Clears the pipe on every clock of reset.
- Hazard terms:
  - load_use = MemRead_EX & rd_EX≠0 & ((rs1_used_ID & rs1_ID==rd_EX) | (rs2_used_ID & rs2_ID==rd_EX)).
  - mem_stall = dmem_req_MEM & ~dmem_ready & ~abort, where abort = wait counter reached MEM_TIMEOUT-1.
- Priority, highest first:
  1. mem_stall: every *_EN=0, both flushes=0; the whole pipe freezes.
  2. branch_taken_EX: PC_EN=1, IF_ID_flush=1, ID_EX_flush=1, others enabled. Overrides load_use and imem wait; the squashed instructions are younger.
  3. load_use: PC_EN=0, IF_ID_EN=0, ID_EX_flush=1, EX_MEM_EN=MEM_WB_EN=1. Inserts exactly one bubble; the next cycle the load is in MEM, so load_use deasserts.
  4. ~imem_ready: PC_EN=0, IF_ID_flush=1, rest run.
  5. Otherwise all EN=1, flushes=0.
- FSM:
  - RUN→MEM_WAIT when mem_stall; wait counter←1.
  - MEM_WAIT: counter increments each cycle mem_stall holds.
  - MEM_WAIT→RUN on dmem_ready. Counter←0; the pipe advances that cycle.
  - MEM_WAIT→RUN when abort: pipe advances as if ready, mem_timeout=1 for the next cycle, counter←0.
  - dmem_req_MEM dropping during MEM_WAIT→RUN, no timeout.
- A branch_taken_EX during a freeze is held by the frozen EX stage and is acted on in the release cycle.
- rst mid-MEM_WAIT returns to RUN immediately; no mem_timeout pulse.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined:
  - Adds outputs cnt_load_use, cnt_flush, cnt_mem_wait (each CNT_W).
  - Each increments per cycle its condition drives the outputs; cnt_flush counts branch redirects.
  - Saturating at all-ones, cleared by rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg: state encoding (RUN/MEM_WAIT), REG_ADDR_W=5, ZERO_REG constant.
- One sub-module hazard_detect (combinational load_use compare), reused later by the forwarding unit.

Test Plan:
- Reset: rst=1 two cycles → all EN=1, both flushes=1, state 0; after release with no hazards → flushes 0.
- Load-use: MemRead_EX=1, rd_EX=5, rs1_ID=5, rs1_used_ID=1 → PC_EN=0, IF_ID_EN=0, ID_EX_flush=1 for one cycle. Same with rd_EX=0 → no stall.
- Branch + load-use same cycle: branch_taken_EX=1 with load_use true → PC_EN=1, IF_ID_flush=1, ID_EX_flush=1.
- Mem wait: dmem_req_MEM=1, dmem_ready low 3 cycles then high → all EN=0 for 3 cycles, state_o=1, release on the 4th cycle, no mem_timeout.
- Timeout: dmem_ready held 0 with MEM_TIMEOUT=16 → frozen 15 cycles, pipe advances on the 16th, mem_timeout pulses on the 17th, state RUN.
- Reset mid-wait: rst=1 on wait cycle 5 → state 0 next cycle, counter cleared, no mem_timeout.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: sequencer state encoding and register-file addressing constants.
package pipe_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: EX-stage load whose destination feeds an ID-stage source operand.
// Pure combinational compare, zero latency, no backpressure of its own.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  mem_read_ex,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = rs1_used_id && (rs1_id == rd_ex);
    rs2_hit  = rs2_used_id && (rs2_id == rd_ex);
    // x0 is hardwired zero, so a load into it never creates a dependency.
    load_use = mem_read_ex && (rd_ex != ZERO_REG) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe; enables/flushes are same-cycle combinational, state/timeout registered.
// A data-memory wait freezes the whole pipe until ready or timeout; PIPE_PERF_CNT_EN adds saturating event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  rs1_used_ID,
  input  logic                  rs2_used_ID,
  input  logic [REG_ADDR_W-1:0] rd_EX,
  input  logic                  MemRead_EX,
  input  logic                  branch_taken_EX,
  input  logic                  imem_ready,
  input  logic                  dmem_req_MEM,
  input  logic                  dmem_ready,
  output logic                  PC_EN,
  output logic                  IF_ID_EN,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_EN,
  output logic                  ID_EX_flush,
  output logic                  EX_MEM_EN,
  output logic                  MEM_WB_EN,
  output logic                  mem_timeout,
  output logic                  state_o
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0]    cnt_load_use
  , output logic [CNT_W-1:0]    cnt_flush
  , output logic [CNT_W-1:0]    cnt_mem_wait
`endif
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] ABORT_AT = CW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic            load_use;
  logic            abort;
  logic            mem_stall;

  hazard_detect u_hazard_detect (
    .rs1_id      (rs1_ID),
    .rs2_id      (rs2_ID),
    .rs1_used_id (rs1_used_ID),
    .rs2_used_id (rs2_used_ID),
    .rd_ex       (rd_EX),
    .mem_read_ex (MemRead_EX),
    .load_use    (load_use)
  );

  always_comb begin
    abort     = (state_q == MEM_WAIT) && (wait_cnt_q == ABORT_AT);
    mem_stall = dmem_req_MEM && !dmem_ready && !abort;
  end

  always_comb begin
    PC_EN       = 1'b1;
    IF_ID_EN    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_EN    = 1'b1;
    ID_EX_flush = 1'b0;
    EX_MEM_EN   = 1'b1;
    MEM_WB_EN   = 1'b1;
    if (rst) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (mem_stall) begin
      PC_EN     = 1'b0;
      IF_ID_EN  = 1'b0;
      ID_EX_EN  = 1'b0;
      EX_MEM_EN = 1'b0;
      MEM_WB_EN = 1'b0;
    end else if (branch_taken_EX) begin
      // Redirect squashes younger IF/ID work, which also covers any load-use on it.
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (load_use) begin
      PC_EN       = 1'b0;
      IF_ID_EN    = 1'b0;
      ID_EX_flush = 1'b1;
    end else if (!imem_ready) begin
      PC_EN       = 1'b0;
      IF_ID_flush = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end else begin
          state_d       = RUN;
          wait_cnt_d    = '0;
          mem_timeout_d = abort && dmem_req_MEM && !dmem_ready;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_load_use_q, cnt_load_use_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
  logic [CNT_W-1:0] cnt_mem_wait_q, cnt_mem_wait_d;

  // Each event is counted only when it is the term actually steering the controls.
  always_comb begin
    cnt_load_use_d = cnt_load_use_q;
    cnt_flush_d    = cnt_flush_q;
    cnt_mem_wait_d = cnt_mem_wait_q;
    if (mem_stall && (cnt_mem_wait_q != '1))
      cnt_mem_wait_d = cnt_mem_wait_q + CNT_W'(1);
    if (!mem_stall && branch_taken_EX && (cnt_flush_q != '1))
      cnt_flush_d = cnt_flush_q + CNT_W'(1);
    if (!mem_stall && !branch_taken_EX && load_use && (cnt_load_use_q != '1))
      cnt_load_use_d = cnt_load_use_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_load_use_q <= '0;
      cnt_flush_q    <= '0;
      cnt_mem_wait_q <= '0;
    end else begin
      cnt_load_use_q <= cnt_load_use_d;
      cnt_flush_q    <= cnt_flush_d;
      cnt_mem_wait_q <= cnt_mem_wait_d;
    end
  end

  assign cnt_load_use = cnt_load_use_q;
  assign cnt_flush    = cnt_flush_q;
  assign cnt_mem_wait = cnt_mem_wait_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of single-cycle hazard vectors plus multi-cycle wait/timeout/reset sequences.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic       rs1_used_ID, rs2_used_ID, MemRead_EX, branch_taken_EX;
  logic       imem_ready, dmem_req_MEM, dmem_ready;
  logic       PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, MEM_WB_EN;
  logic       mem_timeout, state_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cnt_load_use, cnt_flush, cnt_mem_wait;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .rs1_used_ID     (rs1_used_ID),
    .rs2_used_ID     (rs2_used_ID),
    .rd_EX           (rd_EX),
    .MemRead_EX      (MemRead_EX),
    .branch_taken_EX (branch_taken_EX),
    .imem_ready      (imem_ready),
    .dmem_req_MEM    (dmem_req_MEM),
    .dmem_ready      (dmem_ready),
    .PC_EN           (PC_EN),
    .IF_ID_EN        (IF_ID_EN),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_EN        (ID_EX_EN),
    .ID_EX_flush     (ID_EX_flush),
    .EX_MEM_EN       (EX_MEM_EN),
    .MEM_WB_EN       (MEM_WB_EN),
    .mem_timeout     (mem_timeout),
    .state_o         (state_o)
`ifdef PIPE_PERF_CNT_EN
    , .cnt_load_use  (cnt_load_use)
    , .cnt_flush     (cnt_flush)
    , .cnt_mem_wait  (cnt_mem_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, MEM_WB_EN}
  localparam logic [6:0] E_NORM   = 7'b1101011;
  localparam logic [6:0] E_LU     = 7'b0001111;
  localparam logic [6:0] E_BR     = 7'b1111111;
  localparam logic [6:0] E_IMEM   = 7'b0111011;
  localparam logic [6:0] E_FREEZE = 7'b0000000;
  localparam logic [6:0] E_RST    = 7'b1111111;

  logic [6:0] en_vec;
  assign en_vec = {PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, MEM_WB_EN};

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       im;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];
  int   n_pass;
  int   n_total;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    rs1_ID = 5'd1; rs2_ID = 5'd2; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
    rd_EX = 5'd0; MemRead_EX = 1'b0; branch_taken_EX = 1'b0; imem_ready = 1'b1;
    dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
  endtask

  // Hold dmem_ready low from a RUN state: expect 15 frozen cycles, advance on the 16th, pulse on the 17th.
  task automatic run_timeout(input string nm);
    int frozen;
    bit done;
    frozen = 0;
    done   = 1'b0;
    dmem_req_MEM = 1'b1;
    dmem_ready   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (en_vec == E_FREEZE) begin
        frozen++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    chk({nm, "_released"}, int'(done), 1);
    chk({nm, "_frozen_cycles"}, frozen, 15);
    chk({nm, "_adv_en"}, int'(en_vec), int'(E_NORM));
    chk({nm, "_adv_no_pulse_yet"}, int'(mem_timeout), 0);
    tick();
    dmem_req_MEM = 1'b0;
    #1;
    chk({nm, "_pulse"}, int'(mem_timeout), 1);
    chk({nm, "_state_run"}, int'(state_o), 0);
    tick();
    chk({nm, "_pulse_one_cycle"}, int'(mem_timeout), 0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    //             rs1    rs2    u1    u2    rd     mr    br    im    exp
    vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, E_NORM};
    vecs[1]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, E_LU};
    vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, E_NORM};
    vecs[3]  = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, E_LU};
    vecs[4]  = '{5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, E_NORM};
    vecs[5]  = '{5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, E_NORM};
    vecs[6]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, E_NORM};
    vecs[7]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, E_BR};
    vecs[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_IMEM};
    vecs[9]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_LU};
    vecs[10] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, E_BR};

    // Reset: two cycles, with a pending data wait that reset must override.
    rst = 1'b1;
    quiet_inputs();
    dmem_req_MEM = 1'b1;
    tick();
    tick();
    chk("rst_controls", int'(en_vec), int'(E_RST));
    chk("rst_state", int'(state_o), 0);
    chk("rst_timeout", int'(mem_timeout), 0);
    rst = 1'b0;
    dmem_req_MEM = 1'b0;
    #1;
    chk("post_rst_controls", int'(en_vec), int'(E_NORM));

    foreach (vecs[k]) begin
      rs1_ID = vecs[k].rs1; rs2_ID = vecs[k].rs2;
      rs1_used_ID = vecs[k].u1; rs2_used_ID = vecs[k].u2;
      rd_EX = vecs[k].rd; MemRead_EX = vecs[k].mr;
      branch_taken_EX = vecs[k].br; imem_ready = vecs[k].im;
      #1;
      chk($sformatf("vec%0d_controls", k), int'(en_vec), int'(vecs[k].exp));
      tick();
    end

    // Load-use bubble lasts one cycle: next cycle the load has moved to MEM.
    quiet_inputs();
    rs1_ID = 5'd5; rs1_used_ID = 1'b1; rd_EX = 5'd5; MemRead_EX = 1'b1;
    #1;
    chk("lu_stall", int'(en_vec), int'(E_LU));
    tick();
    MemRead_EX = 1'b0; rd_EX = 5'd9; dmem_req_MEM = 1'b1; dmem_ready = 1'b1;
    #1;
    chk("lu_released", int'(en_vec), int'(E_NORM));
    tick();

    // Three-cycle data wait with a branch held in the frozen EX stage.
    quiet_inputs();
    dmem_req_MEM = 1'b1;
    branch_taken_EX = 1'b1;
    #1;
    chk("mw_c1_freeze", int'(en_vec), int'(E_FREEZE));
    chk("mw_c1_state", int'(state_o), 0);
    tick();
    chk("mw_c2_freeze", int'(en_vec), int'(E_FREEZE));
    chk("mw_c2_state", int'(state_o), 1);
    tick();
    chk("mw_c3_freeze", int'(en_vec), int'(E_FREEZE));
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("mw_c4_release_branch", int'(en_vec), int'(E_BR));
    chk("mw_c4_state", int'(state_o), 1);
    tick();
    quiet_inputs();
    #1;
    chk("mw_after_state", int'(state_o), 0);
    chk("mw_no_timeout", int'(mem_timeout), 0);
    chk("mw_after_controls", int'(en_vec), int'(E_NORM));

    run_timeout("to");

    // Request dropped mid-wait returns to RUN without a timeout.
    dmem_req_MEM = 1'b1;
    tick();
    tick();
    dmem_req_MEM = 1'b0;
    #1;
    chk("drop_controls", int'(en_vec), int'(E_NORM));
    tick();
    chk("drop_state", int'(state_o), 0);
    chk("drop_no_timeout", int'(mem_timeout), 0);

    // Reset on wait cycle 5.
    dmem_req_MEM = 1'b1;
    dmem_ready   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    chk("rmw_controls", int'(en_vec), int'(E_RST));
    tick();
    rst = 1'b0;
    dmem_req_MEM = 1'b0;
    #1;
    chk("rmw_state", int'(state_o), 0);
    chk("rmw_no_timeout", int'(mem_timeout), 0);
    tick();
    chk("rmw_no_timeout_later", int'(mem_timeout), 0);
    run_timeout("rmw_full");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
